complex_addsub_acc: RTL

- Parametrised, pipelined complex arithmetic unit for the datapath.
- Successor to the fixed-width single-register complex adder.
- Adds per-sample mode select (add, subtract, accumulate, load), a valid handshake, configurable pipeline depth and optional saturation with an overflow flag.
- Sits between the complex multiplier stage and downstream butterfly/accumulation logic.

---
 rtl/complex_arith_pkg.sv | 52 +++++
 rtl/complex_pipe_delay.sv | 64 ++++++
 rtl/complex_addsub_acc.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/complex_arith_pkg.sv
// Shared definitions for the complex arithmetic datapath.
//   - mode_t        : per-sample operation select for complex_addsub_acc
//   - WL_DEF/WL_OUT_DEF : word lengths shared with the complex multiplier
//   - sext / fit    : width-generic sign-extension and saturate/wrap helpers.
//     Both work on a CALC_W-bit container; callers pass the live width and
//     slice the low bits of the result.
package complex_arith_pkg;

   localparam int WL_DEF     = 14;
   localparam int WL_OUT_DEF = WL_DEF + 1;
   localparam int CALC_W     = 32;

   typedef enum logic [1:0] {
      MODE_ADD  = 2'b00,
      MODE_SUB  = 2'b01,
      MODE_ACC  = 2'b10,
      MODE_LOAD = 2'b11
   } mode_t;

   typedef struct packed {
      logic                ovf;
      logic [CALC_W-1:0]   value;
   } fit_t;

   // Sign-extend the low w bits of x to the full container width.
   function automatic logic signed [CALC_W-1:0] sext(input logic [CALC_W-1:0] x,
                                                     input int w);
      logic [CALC_W-1:0] sh;
      sh = x << (CALC_W - w);
      return $signed(sh) >>> (CALC_W - w);
   endfunction

   // Fit a sum into a w-bit signed range: clamp when sat is set, otherwise
   // keep the low w bits (re-extended so the container stays consistent).
   function automatic fit_t fit(input logic signed [CALC_W-1:0] sum,
                                input int w,
                                input logic sat);
      logic signed [CALC_W-1:0] hi;
      logic signed [CALC_W-1:0] lo;
      fit_t r;
      hi = (CALC_W'(1) << (w - 1)) - 32'sd1;
      lo = -hi - 32'sd1;
      r.ovf = (sum > hi) || (sum < lo);
      if (r.ovf && sat) begin
         r.value = (sum > hi) ? hi : lo;
      end else begin
         r.value = sext(sum, w);
      end
      return r;
   endfunction

endpackage

// File: rtl/complex_pipe_delay.sv
// Fixed-depth delay line for a {valid, re, im, flag} bundle.
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   valid, re, im, flag     bundle entering the line
//   dly_valid, dly_re,
//   dly_im, dly_flag        bundle DEPTH cycles later (DEPTH=0: passthrough)
module complex_pipe_delay #(
   parameter int W     = 15,
   parameter int DEPTH = 0
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         valid,
   input  logic [W-1:0] re,
   input  logic [W-1:0] im,
   input  logic         flag,
   output logic         dly_valid,
   output logic [W-1:0] dly_re,
   output logic [W-1:0] dly_im,
   output logic         dly_flag
);

   if (DEPTH == 0) begin : g_pass
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ reset;
      assign dly_valid = valid;
      assign dly_re    = re;
      assign dly_im    = im;
      assign dly_flag  = flag;
   end else begin : g_chain
      logic [DEPTH-1:0] v_q;
      logic [DEPTH-1:0] f_q;
      logic [W-1:0]     re_q [DEPTH];
      logic [W-1:0]     im_q [DEPTH];

      always_ff @(posedge clk) begin
         if (reset) begin
            v_q <= '0;
            f_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
               re_q[i] <= '0;
               im_q[i] <= '0;
            end
         end else begin
            v_q[0]  <= valid;
            f_q[0]  <= flag;
            re_q[0] <= re;
            im_q[0] <= im;
            for (int i = 1; i < DEPTH; i++) begin
               v_q[i]  <= v_q[i-1];
               f_q[i]  <= f_q[i-1];
               re_q[i] <= re_q[i-1];
               im_q[i] <= im_q[i-1];
            end
         end
      end

      assign dly_valid = v_q[DEPTH-1];
      assign dly_flag  = f_q[DEPTH-1];
      assign dly_re    = re_q[DEPTH-1];
      assign dly_im    = im_q[DEPTH-1];
   end

endmodule

// File: rtl/complex_addsub_acc.sv
// Pipelined complex add / subtract / accumulate / load unit.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   in_valid          input sample qualifier (no backpressure)
//   mode              00 add, 01 sub, 10 acc += a, 11 acc = a
//   ar, ai, br, bi    signed operands, WL bits (b ignored for acc/load)
//   out_valid         one-cycle result qualifier, PIPE cycles after acceptance
//   cr, ci            signed result, WL_OUT bits; hold last valid result
//   ovf               accumulate overflow on either component, gated by out_valid
module complex_addsub_acc
   import complex_arith_pkg::*;
#(
   parameter int WL     = WL_DEF,
   parameter int WL_OUT = WL + 1,
   parameter int PIPE   = 1,
   parameter bit SAT    = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [1:0]        mode,
   input  logic [WL-1:0]     ar,
   input  logic [WL-1:0]     ai,
   input  logic [WL-1:0]     br,
   input  logic [WL-1:0]     bi,
   output logic              out_valid,
   output logic [WL_OUT-1:0] cr,
   output logic [WL_OUT-1:0] ci,
   output logic              ovf
);

   if (WL_OUT < WL + 1) begin : g_bad_wl_out
      $error("complex_addsub_acc: WL_OUT must be at least WL+1");
   end
   if (WL_OUT + 1 > CALC_W) begin : g_bad_width
      $error("complex_addsub_acc: WL_OUT too wide for the arithmetic container");
   end
   if (PIPE < 1 || PIPE > 4) begin : g_bad_pipe
      $error("complex_addsub_acc: PIPE must be in 1..4");
   end

   logic              s1_valid;
   logic              s1_ovf;
   logic [WL_OUT-1:0] s1_re;
   logic [WL_OUT-1:0] s1_im;
   logic [WL_OUT-1:0] acc_r;
   logic [WL_OUT-1:0] acc_i;

   logic [CALC_W-1:0] a_r_x, a_i_x, b_r_x, b_i_x, acc_r_x, acc_i_x;
   logic [CALC_W-1:0] add_r, add_i, sub_r, sub_i;
   fit_t              fit_r, fit_i;

   // Everything is evaluated in a wide container; WL_OUT >= WL+1 means add
   // and sub results always fit, so slicing them is exact.
   assign a_r_x   = sext(CALC_W'(ar), WL);
   assign a_i_x   = sext(CALC_W'(ai), WL);
   assign b_r_x   = sext(CALC_W'(br), WL);
   assign b_i_x   = sext(CALC_W'(bi), WL);
   assign acc_r_x = sext(CALC_W'(acc_r), WL_OUT);
   assign acc_i_x = sext(CALC_W'(acc_i), WL_OUT);

   assign add_r = a_r_x + b_r_x;
   assign add_i = a_i_x + b_i_x;
   assign sub_r = a_r_x - b_r_x;
   assign sub_i = a_i_x - b_i_x;

   always_comb begin
      fit_r = fit(acc_r_x + a_r_x, WL_OUT, SAT);
      fit_i = fit(acc_i_x + a_i_x, WL_OUT, SAT);
   end

   logic              unused_hi;
   assign unused_hi = ^{add_r[CALC_W-1:WL_OUT], add_i[CALC_W-1:WL_OUT],
                        sub_r[CALC_W-1:WL_OUT], sub_i[CALC_W-1:WL_OUT],
                        a_r_x[CALC_W-1:WL_OUT], a_i_x[CALC_W-1:WL_OUT],
                        fit_r.value[CALC_W-1:WL_OUT], fit_i.value[CALC_W-1:WL_OUT]};

   logic [WL_OUT-1:0] nxt_re, nxt_im;
   logic              nxt_ovf;
   logic              acc_we;

   always_comb begin
      nxt_re  = add_r[WL_OUT-1:0];
      nxt_im  = add_i[WL_OUT-1:0];
      nxt_ovf = 1'b0;
      acc_we  = 1'b0;
      case (mode_t'(mode))
         MODE_ADD: begin
            nxt_re = add_r[WL_OUT-1:0];
            nxt_im = add_i[WL_OUT-1:0];
         end
         MODE_SUB: begin
            nxt_re = sub_r[WL_OUT-1:0];
            nxt_im = sub_i[WL_OUT-1:0];
         end
         MODE_ACC: begin
            nxt_re  = fit_r.value[WL_OUT-1:0];
            nxt_im  = fit_i.value[WL_OUT-1:0];
            nxt_ovf = fit_r.ovf | fit_i.ovf;
            acc_we  = 1'b1;
         end
         MODE_LOAD: begin
            nxt_re = a_r_x[WL_OUT-1:0];
            nxt_im = a_i_x[WL_OUT-1:0];
            acc_we = 1'b1;
         end
         default: ;
      endcase
   end

   // Stage-1 data only changes on an accepted sample, so bubbles carry the
   // last valid result down the delay line and the output holds it for free.
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid <= 1'b0;
         s1_ovf   <= 1'b0;
         s1_re    <= '0;
         s1_im    <= '0;
         acc_r    <= '0;
         acc_i    <= '0;
      end else begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_re  <= nxt_re;
            s1_im  <= nxt_im;
            s1_ovf <= nxt_ovf;
            if (acc_we) begin
               acc_r <= nxt_re;
               acc_i <= nxt_im;
            end
         end
      end
   end

   logic last_flag;

   complex_pipe_delay #(
      .W     (WL_OUT),
      .DEPTH (PIPE - 1)
   ) u_delay (
      .clk       (clk),
      .reset     (reset),
      .valid     (s1_valid),
      .re        (s1_re),
      .im        (s1_im),
      .flag      (s1_ovf),
      .dly_valid (out_valid),
      .dly_re    (cr),
      .dly_im    (ci),
      .dly_flag  (last_flag)
   );

   assign ovf = out_valid & last_flag;

endmodule
